// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: widths, FSM states and the queue entry.
package fetch_pkg;

  localparam int unsigned PC_W   = 30;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Fetch-side bundle: instruction-memory req/ack, decode valid/ready and redirect.
interface fetch_seq_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              redir_valid;
  logic [PC_W-1:0]   redir_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redir_valid, redir_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redir_valid, redir_target
  );

endinterface

// File: rtl/fetch_seq_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, issues imem requests, queues words for decode, applies redirects.
// Optional FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned     QDEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  fetch_seq_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  addr_q;
  logic             req_q;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] occ_after;
  entry_t           push_entry;
  entry_t           head;

  assign pc_inc     = pc + PC_W'(1);
  assign pop        = ~q_empty & bus.inst_ready;
  assign push       = (state == REQ) & bus.imem_ack & ~bus.redir_valid;
  assign occ_after  = q_count + CNT_W'(1) - CNT_W'(pop);
  assign push_entry = '{pc: pc, inst: bus.imem_rdata};

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = ~q_empty;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redir_valid),
    .data  (push_entry),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (head)
  );

  // Request FSM; an issued request stays on the bus until acked, even across redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.redir_valid) begin
            pc     <= bus.redir_target;
            addr_q <= bus.redir_target;
            req_q  <= 1'b1;
            state  <= REQ;
          end else if (!q_full) begin
            addr_q <= pc;
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (bus.redir_valid) begin
            pc <= bus.redir_target;
            if (bus.imem_ack) addr_q <= bus.redir_target;
            else              state  <= DISCARD;
          end else if (bus.imem_ack) begin
            pc <= pc_inc;
            if (occ_after < CNT_W'(QDEPTH)) begin
              addr_q <= pc_inc;
            end else begin
              req_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (bus.redir_valid) pc <= bus.redir_target;
          if (bus.imem_ack) begin
            addr_q <= bus.redir_valid ? bus.redir_target : pc;
            state  <= REQ;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (req_q && !bus.imem_ack && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.redir_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: the memory responder predicts the delivered stream, a monitor checks it.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_seq;
  import fetch_pkg::*;

  localparam int unsigned     QDEPTH   = 2;
  localparam logic [PC_W-1:0] RESET_PC = 30'h0;

  logic clk = 1'b0;
  logic rst;

  fetch_seq_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_seq #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream model: the decode stage must see path_pc, path_pc+1, ... from the last redirect target.
  entry_t          exp_q[$];
  logic [PC_W-1:0] path_pc;
  logic            stale;
  logic            hold_valid;
  logic [PC_W-1:0] hold_addr;
  int lat_mode, ready_mode, fixed_lat, cur_lat, wait_cnt;
  int n_push, held5;
  int m_fetch, m_stall, m_flush;
  logic            rand_redir, force_redir, trig_en;
  logic [PC_W-1:0] force_tgt, trig_addr, trig_tgt;

  function automatic logic [INST_W-1:0] word_of(logic [PC_W-1:0] a);
    return {a[13:0], a[29:12]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    path_pc    = RESET_PC;
    stale      = 1'b0;
    hold_valid = 1'b0;
    wait_cnt   = 0;
    m_fetch    = 0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_req"},   64'(bus.imem_req),   64'd0);
    chk({tag, "_addr"},  64'(bus.imem_addr),  64'(RESET_PC));
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd0);
    chk({tag, "_inst"},  64'(bus.inst),       64'd0);
    chk({tag, "_pc"},    64'(bus.inst_pc),    64'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetch"}, 64'(perf_fetch_cnt), 64'd0);
    chk({tag, "_perf_stall"}, 64'(perf_stall_cnt), 64'd0);
    chk({tag, "_perf_flush"}, 64'(perf_flush_cnt), 64'd0);
`endif
  endtask

  // One cycle: called at a falling edge, plays memory/decode/execute, updates the model after the rising edge.
  task automatic step();
    logic            req, ack, rdy, rd, do_push;
    logic [PC_W-1:0] addr, tgt;
    req  = bus.imem_req;
    addr = bus.imem_addr;
    if (hold_valid) begin
      chk("req_held", 64'(req), 64'd1);
      chk("addr_held", 64'(addr), 64'(hold_addr));
    end
    ack = 1'b0;
    if (req) begin
      if (lat_mode == 0)             ack = 1'b1;
      else if (lat_mode == 3)        ack = 1'b0;
      else if (wait_cnt >= cur_lat)  ack = 1'b1;
      else                           wait_cnt++;
    end
    if (ack) begin
      wait_cnt = 0;
      cur_lat  = (lat_mode == 1) ? int'($urandom_range(0, 3)) : fixed_lat;
    end
    rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    rd  = 1'b0;
    tgt = PC_W'($urandom());
    if (force_redir) begin
      rd = 1'b1; tgt = force_tgt; force_redir = 1'b0;
    end else if (trig_en && req && ack && addr == trig_addr) begin
      rd = 1'b1; tgt = trig_tgt; trig_en = 1'b0;
    end else if (rand_redir && $urandom_range(0, 11) == 0) begin
      rd  = 1'b1;
      tgt = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFF0 + PC_W'($urandom_range(0, 15))
                                        : PC_W'($urandom());
    end
    bus.imem_ack     = ack;
    bus.imem_rdata   = ack ? word_of(addr) : $urandom();
    bus.inst_ready   = rdy;
    bus.redir_valid  = rd;
    bus.redir_target = tgt;
    do_push = 1'b0;
    if (ack) begin
      if (stale) stale = 1'b0;
      else begin
        chk("fetch_addr", 64'(addr), 64'(path_pc));
        do_push = !rd;
      end
    end else if (rd && req) begin
      stale = 1'b1;
    end
    if (req && addr == 30'd5) held5++;
    hold_valid = req && !ack;
    hold_addr  = addr;
    if (req && !ack) m_stall++;
    if (rd) m_flush++;
    if (do_push) begin m_fetch++; n_push++; end
    @(posedge clk);
    #1;
    if (do_push) begin
      exp_q.push_back('{pc: path_pc, inst: word_of(path_pc)});
      path_pc = path_pc + PC_W'(1);
    end
    if (rd) path_pc = tgt;
    @(negedge clk);
  endtask

  // Monitor: occupancy, head contents on every pop, flush on redirect.
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
        if (bus.inst_valid && bus.inst_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
          chk("inst", 64'(bus.inst), 64'(e.inst));
        end
        if (bus.redir_valid) exp_q.delete();
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    bus.redir_valid = 1'b0; bus.redir_target = '0;
    lat_mode = 0; ready_mode = 1; fixed_lat = 0; cur_lat = 0;
    n_push = 0; held5 = 0;
    rand_redir = 1'b0; force_redir = 1'b0; trig_en = 1'b0;
    force_tgt = '0; trig_addr = '0; trig_tgt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Same-cycle acks, decode always ready: one word per cycle.
    for (int k = 0; k < 12; k++) begin
      if (k >= 1) chk("stream_req", 64'(bus.imem_req), 64'd1);
      if (k >= 2) chk("stream_valid", 64'(bus.inst_valid), 64'd1);
      step();
    end

    // Reset in the middle of a request.
    rst = 1'b1;
    #1;
    check_reset("mid");
    model_reset();
    bus.imem_ack = 1'b0; bus.redir_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Decode stalled: issue stops once the queue is full, then resumes.
    ready_mode = 0; n_push = 0;
    repeat (8) step();
    chk("full_pushes", 64'(n_push), 64'(QDEPTH));
    chk("full_req_low", 64'(bus.imem_req), 64'd0);
    ready_mode = 1;
    repeat (8) step();

    // Three-cycle memory latency on address 5.
    lat_mode = 0; fixed_lat = 2; force_redir = 1'b1; force_tgt = 30'd5;
    step();
    lat_mode = 2; cur_lat = 2; wait_cnt = 0; held5 = 0;
    repeat (8) step();
    chk("lat_hold5", 64'(held5), 64'd3);

    // Redirect to 0x100 while the request for 7 is outstanding.
    lat_mode = 0; force_redir = 1'b1; force_tgt = 30'd7;
    step();
    lat_mode = 3;
    step();
    force_redir = 1'b1; force_tgt = 30'h100;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("discard_req", 64'(bus.imem_req), 64'd1);
      chk("discard_addr", 64'(bus.imem_addr), 64'd7);
      step();
    end
    lat_mode = 0;
    repeat (8) step();

    // Redirect to 0x40 in the same cycle as the ack for 9 and a pop of 8.
    force_redir = 1'b1; force_tgt = 30'd8;
    trig_en = 1'b1; trig_addr = 30'd9; trig_tgt = 30'h40;
    repeat (8) step();
    chk("trig_fired", 64'(trig_en), 64'd0);

    // PC wrap.
    force_redir = 1'b1; force_tgt = 30'h3FFF_FFFF;
    repeat (6) step();

    // Random latency, back-pressure and redirects.
    lat_mode = 1; ready_mode = 2; rand_redir = 1'b1;
    repeat (3000) step();
    rand_redir = 1'b0; ready_mode = 1; lat_mode = 0;
    repeat (10) step();

`ifdef FETCH_PERF_EN
    chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
    chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
    chk("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
